// File: rtl/qupls_preg_freelist_pkg.sv
// Shared types, sizes and helpers for the physical register free list.
//   PREGS/AREGS : physical / architectural register counts
//   RBIT        : width of a physical register number
//   preg_slot_t : one ready-buffer entry {rg, v}
//   rank4       : number of set bits below position k in a 4-bit vector
//   popcnt_preg : population count of a PREGS-wide vector
package qupls_preg_freelist_pkg;
  localparam int PREGS  = 96;
  localparam int AREGS  = 64;
  localparam int RBIT   = $clog2(PREGS);
  localparam int NALLOC = 4;
  localparam int NFREE  = 4;

  typedef logic [RBIT-1:0] pregno_t;

  typedef struct packed {
    pregno_t rg;
    logic    v;
  } preg_slot_t;

  // pregs 0..AREGS-1 hold the initial identity map, everything above is free
  localparam logic [PREGS-1:0] FREE_RST = {{(PREGS-AREGS){1'b1}}, {AREGS{1'b0}}};
  localparam logic [RBIT:0]    CNT_RST  = (RBIT+1)'(PREGS-AREGS);

  function automatic logic [2:0] rank4(input logic [3:0] v, input int k);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 4; i++)
      if (i < k && v[i]) c = c + 3'd1;
    return c;
  endfunction

  function automatic logic [RBIT:0] popcnt_preg(input logic [PREGS-1:0] v);
    logic [RBIT:0] c;
    c = '0;
    for (int i = 0; i < PREGS; i++)
      c = c + {{RBIT{1'b0}}, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/qupls_preg_freelist_find_first4.sv
// Combinational finder: the four lowest set-bit indices of a PREGS vector.
//   vec : input bit vector
//   idx : found indices, idx[0] is the lowest
//   vld : per-index valid (fewer than four bits set leaves the upper ones 0)
module qupls_find_first4
  import qupls_preg_freelist_pkg::*;
(
  input  logic [PREGS-1:0] vec,
  output pregno_t [3:0]    idx,
  output logic [3:0]       vld
);
  always_comb begin
    logic [2:0] n;
    n   = '0;
    idx = '0;
    vld = '0;
    for (int i = 0; i < PREGS; i++) begin
      if (vec[i] && n != 3'd4) begin
        idx[n[1:0]] = pregno_t'(i);
        vld[n[1:0]] = 1'b1;
        n = n + 3'd1;
      end
    end
  end
endmodule

// File: rtl/qupls_preg_freelist.sv
// Physical register free list / allocator feeding the register alias table.
//   clk, rst      : clock, synchronous active-high reset
//   alloc_req     : per-slot rename request
//   alloc_preg    : allocated register per slot (0 when not granted)
//   alloc_gnt     : per-slot grant, alloc_req gated by stall_o
//   stall_o       : not enough ready registers, or restore in progress
//   free_v/preg   : commit-time register returns
//   restore       : branch-miss restore, returns free_bitlist
//   avail_o       : registered free vector | ready-buffer membership
//   free_cnt      : registered popcount of avail_o
//   err_dblfree   : one-cycle pulse, a returned register was already available
module qupls_preg_freelist
  import qupls_preg_freelist_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NALLOC-1:0]      alloc_req,
  output logic [NALLOC*RBIT-1:0] alloc_preg,
  output logic [NALLOC-1:0]      alloc_gnt,
  output logic                   stall_o,
  input  logic [NFREE-1:0]       free_v,
  input  logic [NFREE*RBIT-1:0]  free_preg,
  input  logic                   restore,
  input  logic [PREGS-1:0]       free_bitlist,
  output logic [PREGS-1:0]       avail_o,
  output logic [RBIT:0]          free_cnt,
  output logic                   err_dblfree
);
  preg_slot_t [NALLOC-1:0] slot_q, slot_d;
  logic [NALLOC-1:0] slot_v, consumed, empty;
  logic [PREGS-1:0]  free_vec, free_d, taken, ret, ret_ok, rdy_mask, rdy_mask_d, avail_d;
  pregno_t [3:0]     ff_idx;
  logic [3:0]        ff_vld;
  logic              dbl;

  qupls_find_first4 u_ff (.vec(free_vec), .idx(ff_idx), .vld(ff_vld));

  // Allocation: the k-th request takes the k-th valid slot. When not
  // stalled there are always enough valid slots, so ranks match one to one.
  always_comb begin
    for (int j = 0; j < NALLOC; j++) slot_v[j] = slot_q[j].v;
    stall_o    = restore | (rank4(alloc_req, 4) > rank4(slot_v, 4));
    alloc_gnt  = alloc_req & ~{NALLOC{stall_o}};
    alloc_preg = '0;
    consumed   = '0;
    for (int r = 0; r < NALLOC; r++)
      for (int j = 0; j < NALLOC; j++)
        if (alloc_gnt[r] && slot_v[j] && rank4(alloc_req, r) == rank4(slot_v, j)) begin
          alloc_preg[r*RBIT +: RBIT] = slot_q[j].rg;
          consumed[j] = 1'b1;
        end
  end

  // Refill: empty or consumed slots, in slot order, take the lowest free
  // registers of the current free_vec.
  always_comb begin
    logic [1:0] e;
    e      = '0;
    empty  = ~slot_v | consumed;
    slot_d = slot_q;
    taken  = '0;
    for (int j = 0; j < NALLOC; j++) begin
      if (empty[j]) begin
        e = 2'(rank4(empty, j));
        slot_d[j].v  = ff_vld[e];
        slot_d[j].rg = ff_vld[e] ? ff_idx[e] : '0;
        if (ff_vld[e]) taken[ff_idx[e]] = 1'b1;
      end
    end
  end

  // Returns: frees and restore bits merge; anything already available is
  // flagged and dropped so a register never sits in two places.
  always_comb begin
    ret = '0;
    for (int i = 0; i < NFREE; i++)
      if (free_v[i]) ret[free_preg[i*RBIT +: RBIT]] = 1'b1;
    if (restore) ret = ret | free_bitlist;
    ret[0] = 1'b0;
    rdy_mask   = '0;
    rdy_mask_d = '0;
    for (int j = 0; j < NALLOC; j++) begin
      if (slot_q[j].v) rdy_mask[slot_q[j].rg] = 1'b1;
      if (slot_d[j].v) rdy_mask_d[slot_d[j].rg] = 1'b1;
    end
    dbl     = |(ret & (free_vec | rdy_mask));
    ret_ok  = ret & ~(free_vec | rdy_mask);
    // taken comes from the current free_vec and ret_ok excludes it: no overlap
    free_d  = (free_vec & ~taken) | ret_ok;
    avail_d = free_d | rdy_mask_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_vec    <= FREE_RST;
      slot_q      <= '0;
      avail_o     <= FREE_RST;
      free_cnt    <= CNT_RST;
      err_dblfree <= 1'b0;
    end else begin
      free_vec    <= free_d;
      slot_q      <= slot_d;
      avail_o     <= avail_d;
      free_cnt    <= popcnt_preg(avail_d);
      err_dblfree <= dbl;
    end
  end
endmodule

// File: tb/tb_qupls_preg_freelist.sv
// Directed bench for the physical register free list with a grant scoreboard.
module tb_qupls_preg_freelist;
  import qupls_preg_freelist_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NALLOC-1:0]      alloc_req = '0;
  logic [NALLOC*RBIT-1:0] alloc_preg;
  logic [NALLOC-1:0]      alloc_gnt;
  logic                   stall_o;
  logic [NFREE-1:0]       free_v = '0;
  logic [NFREE*RBIT-1:0]  free_preg = '0;
  logic                   restore = 1'b0;
  logic [PREGS-1:0]       free_bitlist = '0;
  logic [PREGS-1:0]       avail_o;
  logic [RBIT:0]          free_cnt;
  logic                   err_dblfree;

  int checks = 0;
  int failures = 0;
  pregno_t exp_q[$];

  qupls_preg_freelist dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_preg(alloc_preg),
    .alloc_gnt(alloc_gnt), .stall_o(stall_o), .free_v(free_v), .free_preg(free_preg),
    .restore(restore), .free_bitlist(free_bitlist), .avail_o(avail_o),
    .free_cnt(free_cnt), .err_dblfree(err_dblfree)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_seq(input int first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(pregno_t'(first + k));
  endtask

  // One cycle: apply request, check combinational outputs mid-cycle, pop the
  // scoreboard for every grant, then step past the edge and idle the inputs.
  task automatic cyc(input logic [3:0] req, input logic exp_stall);
    pregno_t e;
    alloc_req = req;
    @(negedge clk);
    chk("stall", stall_o, exp_stall);
    chk("gnt", alloc_gnt, exp_stall ? 4'b0000 : req);
    for (int r = 0; r < NALLOC; r++) begin
      if (alloc_gnt[r]) begin
        chk("sb_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("alloc_preg", alloc_preg[r*RBIT +: RBIT], e);
        end
      end
    end
    @(posedge clk); #1;
    alloc_req = '0; free_v = '0; free_preg = '0; restore = 1'b0; free_bitlist = '0;
  endtask

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", free_cnt, PREGS - AREGS);
    chk("rst_avail", avail_o, FREE_RST);
    chk("rst_err", err_dblfree, 1'b0);
    chk("rst_preg", alloc_preg, 0);
    cyc(4'b0001, 1'b1);             // slots still empty right after reset
    rst = 1'b0;
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    chk("idle_cnt", free_cnt, PREGS - AREGS);
    chk("idle_avail", avail_o, FREE_RST);

    // three full-width allocations
    for (int k = 0; k < 3; k++) begin
      push_seq(AREGS + 4*k, 4);
      cyc(4'b1111, 1'b0);
      chk("alloc_cnt", free_cnt, PREGS - AREGS - 4*(k+1));
    end

    // drain to 2 available
    for (int k = 0; k < 4; k++) begin
      push_seq(AREGS + 12 + 4*k, 4);
      cyc(4'b1111, 1'b0);
    end
    chk("drain_cnt4", free_cnt, 4);
    push_seq(AREGS + 28, 2);
    cyc(4'b0011, 1'b0);
    chk("drain_cnt2", free_cnt, 2);

    // 3 requests with 2 ready: all-or-nothing stall, then 2 requests succeed
    alloc_req = 4'b0111;
    #1;
    chk("short_stall", stall_o, 1'b1);
    chk("short_gnt", alloc_gnt, 4'b0000);
    push_seq(AREGS + 30, 2);
    cyc(4'b0011, 1'b0);
    chk("empty_cnt", free_cnt, 0);

    // duplicate free of 70 on two ports plus a free of preg 0
    free_v = 4'b0111;
    free_preg = {pregno_t'(0), pregno_t'(0), pregno_t'(70), pregno_t'(70)};
    cyc(4'b0000, 1'b0);
    chk("free_cnt", free_cnt, 1);
    chk("free_avail70", avail_o[70], 1'b1);
    chk("free_avail0", avail_o[0], 1'b0);
    chk("free_err", err_dblfree, 1'b0);
    cyc(4'b0001, 1'b1);             // 70 only reaches the ready buffer at this edge
    chk("refill_cnt", free_cnt, 1);

    // restore 80..83 while requesting
    restore = 1'b1;
    free_bitlist[83:80] = 4'hF;
    cyc(4'b1111, 1'b1);
    chk("rest_avail", avail_o[83:80], 4'hF);
    chk("rest_cnt", free_cnt, 5);
    chk("rest_err", err_dblfree, 1'b0);

    // double free of a free_vec member, then of a ready-buffer member
    free_v = 4'b0001;
    free_preg = {pregno_t'(0), pregno_t'(0), pregno_t'(0), pregno_t'(83)};
    cyc(4'b0000, 1'b0);
    chk("dbl_err", err_dblfree, 1'b1);
    chk("dbl_cnt", free_cnt, 5);
    cyc(4'b0000, 1'b0);
    chk("dbl_pulse", err_dblfree, 1'b0);
    free_v = 4'b0001;
    free_preg = {pregno_t'(0), pregno_t'(0), pregno_t'(0), pregno_t'(81)};
    cyc(4'b0000, 1'b0);
    chk("dbl_rdy_err", err_dblfree, 1'b1);
    chk("dbl_rdy_cnt", free_cnt, 5);
    chk("dbl_rdy_avail", avail_o[83:80], 4'hF);
    cyc(4'b0000, 1'b0);
    chk("dbl_rdy_pulse", err_dblfree, 1'b0);

    // allocate what was returned
    exp_q.push_back(pregno_t'(70));
    push_seq(80, 3);
    cyc(4'b1111, 1'b0);
    chk("post_cnt", free_cnt, 1);
    push_seq(83, 1);
    cyc(4'b0001, 1'b0);
    chk("post_cnt0", free_cnt, 0);

    // reset mid-operation overrides a concurrent free
    rst = 1'b1;
    free_v = 4'b0001;
    free_preg = {pregno_t'(0), pregno_t'(0), pregno_t'(0), pregno_t'(65)};
    cyc(4'b0000, 1'b0);
    chk("mid_rst_cnt", free_cnt, PREGS - AREGS);
    chk("mid_rst_avail", avail_o, FREE_RST);
    chk("mid_rst_err", err_dblfree, 1'b0);
    rst = 1'b0;

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
